// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PID codes, SYNC pattern, FSM states
// and PID classification used by the packet-level receive controller.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_DATA,
        ST_HS_EOP,
        ST_ERR_WAIT,
        ST_ERR_DONE,
        ST_DONE
    } rx_state_e;

    typedef enum logic [1:0] {
        PC_TOKEN,
        PC_DATA,
        PC_HS,
        PC_BAD
    } pid_class_e;

    typedef struct packed {
        logic       valid;
        pid_class_e cls;
    } pid_info_t;

    // Upper nibble must be the complement of the lower; otherwise the PID is bad.
    function automatic pid_info_t pid_valid(input logic [7:0] b);
        pid_info_t r;
        r.cls = PC_BAD;
        if (b[7:4] == ~b[3:0]) begin
            case (b[3:0])
                PID_OUT, PID_IN:              r.cls = PC_TOKEN;
                PID_DATA0, PID_DATA1:         r.cls = PC_DATA;
                PID_ACK, PID_NAK, PID_STALL:  r.cls = PC_HS;
                default:                      r.cls = PC_BAD;
            endcase
        end
        r.valid = (r.cls != PC_BAD);
        return r;
    endfunction

endpackage

// File: rtl/usb_rx_hold2.sv
// Two-byte delay line for DATA payload: the last two bytes of a packet
// (the CRC16) are still held when EOP arrives and are never written out.
module usb_rx_hold2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  logic       emit,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       strobe
);

    logic [7:0] h0_q, h0_d;
    logic [7:0] h1_q, h1_d;
    logic [7:0] dout_q, dout_d;
    logic       strobe_q, strobe_d;

    always_comb begin
        h0_d     = h0_q;
        h1_d     = h1_q;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        if (clr) begin
            h0_d = '0;
            h1_d = '0;
        end else if (push) begin
            h1_d = h0_q;
            h0_d = din;
            if (emit) begin
                dout_d   = h1_q;
                strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h0_q     <= '0;
            h1_q     <= '0;
            dout_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            h0_q     <= h0_d;
            h1_q     <= h1_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
        end
    end

    assign dout   = dout_q;
    assign strobe = strobe_q;

endmodule

// File: rtl/usb_rx_ctrl.sv
// Packet-level USB receive FSM: checks SYNC/PID, counts payload by packet
// type, strips CRC16 from DATA payload and reports status to the bus side.
module usb_rx_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64,
    parameter int OCC_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    input  logic             eop,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic [7:0]       rx_packet_data,
    output logic             store_rx_packet_data,
    output logic             flush,
    output logic [3:0]       rx_packet,
    output logic             rx_data_ready,
    output logic             rx_trans_active,
    output logic             rx_error
);

    localparam int               CNT_W    = $clog2(MAX_PAYLOAD + 3);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_PAYLOAD);

    rx_state_e        state_q, state_d, st_mid;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]       rx_packet_q, rx_packet_d;
    logic             active_q, active_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             flush_q, flush_d;
    logic             is_data_q, is_data_d;
    logic             hold_clr, hold_push, hold_emit;
    logic             frame_ok;
    pid_info_t        pid_info;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_packet_d = rx_packet_q;
        active_d    = active_q;
        err_d       = err_q;
        ready_d     = ready_q;
        flush_d     = 1'b0;
        is_data_d   = is_data_q;
        hold_clr    = 1'b0;
        hold_push   = 1'b0;
        hold_emit   = 1'b0;
        pid_info    = pid_valid(rcv_data);

        if (d_edge)            bit_cnt_d = 3'd0;
        else if (shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;
        // A coincident byte completes first, so judge framing on the updated count.
        frame_ok = (bit_cnt_d == 3'd0);

        st_mid = state_q;
        case (state_q)
            ST_IDLE: if (d_edge) begin
                st_mid    = ST_SYNC;
                active_d  = 1'b1;
                err_d     = 1'b0;
                ready_d   = 1'b0;
                is_data_d = 1'b0;
            end
            ST_SYNC: if (byte_received)
                st_mid = (rcv_data == SYNC_BYTE) ? ST_PID : ST_ERR_WAIT;
            ST_PID: if (byte_received) begin
                byte_cnt_d = '0;
                if (pid_info.valid) rx_packet_d = rcv_data[3:0];
                case (pid_info.cls)
                    PC_TOKEN: st_mid = ST_TOKEN;
                    PC_DATA: begin
                        st_mid    = ST_DATA;
                        flush_d   = 1'b1;
                        is_data_d = 1'b1;
                        hold_clr  = 1'b1;
                    end
                    PC_HS:    st_mid = ST_HS_EOP;
                    default:  st_mid = ST_ERR_WAIT;
                endcase
            end
            ST_TOKEN: if (byte_received) begin
                if (byte_cnt_q == CNT_TWO) st_mid = ST_ERR_WAIT;
                else                       byte_cnt_d = byte_cnt_q + CNT_ONE;
            end
            ST_DATA: if (byte_received) begin
                // Overflow: FIFO full at store time, or payload beyond max plus CRC.
                if (byte_cnt_q == CNT_MAX ||
                    (byte_cnt_q >= CNT_TWO && buffer_occupancy >= OCC_FULL)) begin
                    st_mid = ST_ERR_WAIT;
                end else begin
                    hold_push  = 1'b1;
                    hold_emit  = (byte_cnt_q >= CNT_TWO);
                    byte_cnt_d = byte_cnt_q + CNT_ONE;
                end
            end
            ST_HS_EOP: if (byte_received) st_mid = ST_ERR_WAIT;
            ST_ERR_DONE, ST_DONE: begin
                st_mid   = ST_IDLE;
                active_d = 1'b0;
            end
            default: ;
        endcase

        state_d = st_mid;
        if (eop && state_q != ST_IDLE && state_q != ST_DONE && state_q != ST_ERR_DONE) begin
            case (st_mid)
                ST_TOKEN:  state_d = (frame_ok && byte_cnt_d == CNT_TWO) ? ST_DONE : ST_ERR_DONE;
                ST_DATA:   state_d = (frame_ok && byte_cnt_d >= CNT_TWO) ? ST_DONE : ST_ERR_DONE;
                ST_HS_EOP: state_d = frame_ok ? ST_DONE : ST_ERR_DONE;
                default:   state_d = ST_ERR_DONE;
            endcase
            if (state_d == ST_DONE) begin
                ready_d = (st_mid == ST_DATA);
            end else begin
                err_d   = 1'b1;
                flush_d = is_data_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_packet_q <= '0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            flush_q     <= 1'b0;
            is_data_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_packet_q <= rx_packet_d;
            active_q    <= active_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            flush_q     <= flush_d;
            is_data_q   <= is_data_d;
        end
    end

    usb_rx_hold2 u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr    (hold_clr),
        .push   (hold_push),
        .emit   (hold_emit),
        .din    (rcv_data),
        .dout   (rx_packet_data),
        .strobe (store_rx_packet_data)
    );

    assign flush           = flush_q;
    assign rx_packet       = rx_packet_q;
    assign rx_data_ready   = ready_q;
    assign rx_trans_active = active_q;
    assign rx_error        = err_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: a packet-level outcome model predicts the
// stored bytes, flush count and status; a monitor checks them every cycle.
module tb_usb_rx_ctrl;

    localparam int MAXP = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0, shift_enable = 1'b0, byte_received = 1'b0, eop = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data, flush, rx_data_ready, rx_trans_active, rx_error;
    logic [3:0] rx_packet;

    int total = 0;
    int bad = 0;

    logic [7:0] pkt[$];
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic       e_err = 1'b0, e_ready = 1'b0;
    logic [3:0] e_pid = 4'h0;
    int         e_flush = 0;
    int         flush_seen = 0;
    logic       quiet = 1'b0;

    always #5 clk = ~clk;

    usb_rx_ctrl #(.MAX_PAYLOAD(64), .OCC_W(7)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .d_edge               (d_edge),
        .shift_enable         (shift_enable),
        .byte_received        (byte_received),
        .rcv_data             (rcv_data),
        .eop                  (eop),
        .buffer_occupancy     (buffer_occupancy),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .flush                (flush),
        .rx_packet            (rx_packet),
        .rx_data_ready        (rx_data_ready),
        .rx_trans_active      (rx_trans_active),
        .rx_error             (rx_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (store_rx_packet_data) begin
                log_q.push_back(rx_packet_data);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL store_extra: got store of %0h expected no store", rx_packet_data);
                end else begin
                    check("store_data", rx_packet_data, exp_q.pop_front());
                end
            end
            if (flush) flush_seen++;
            if (quiet)
                check("idle_status", {rx_trans_active, rx_error, rx_data_ready, rx_packet},
                      {1'b0, e_err, e_ready, e_pid});
        end
    end

    // Outcome of a whole packet from its byte list, trailing bit count and FIFO fill.
    task automatic model(input int k, input int occ);
        int         n;
        int         plen;
        int         nst;
        logic [7:0] pb;
        logic [3:0] p;
        n = pkt.size();
        e_err = 1'b1;
        e_ready = 1'b0;
        e_flush = 0;
        if (n >= 2 && pkt[0] == 8'h80) begin
            pb = pkt[1];
            p = pb[3:0];
            if (pb[7:4] == ~p && p inside {4'h1, 4'h9, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE}) begin
                e_pid = p;
                plen = n - 2;
                if (p == 4'h1 || p == 4'h9) begin
                    e_err = (plen != 2) || (k != 0);
                end else if (p == 4'h3 || p == 4'hB) begin
                    e_flush = 1;
                    if (occ >= MAXP && plen >= 3) begin
                        e_err = 1'b1;
                    end else begin
                        nst = (plen < 2) ? 0 : plen - 2;
                        if (nst > MAXP) nst = MAXP;
                        for (int i = 0; i < nst; i++) exp_q.push_back(pkt[2 + i]);
                        e_err = (plen > MAXP + 2) || (plen < 2) || (k != 0);
                    end
                    e_ready = !e_err;
                    if (e_err) e_flush = 2;
                end else begin
                    e_err = (plen != 0) || (k != 0);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            shift_enable = 1'b1;
            byte_received = (i == 7);
            rcv_data = (i == 7) ? b : 8'h00;
            tick();
        end
        shift_enable = 1'b0;
        byte_received = 1'b0;
        tick();
    endtask

    task automatic run_pkt(input int k, input int occ);
        model(k, occ);
        quiet = 1'b0;
        flush_seen = 0;
        log_q.delete();
        buffer_occupancy = 7'(occ);
        tick();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        tick();
        foreach (pkt[i]) send_byte(pkt[i]);
        for (int i = 0; i < k; i++) begin
            shift_enable = 1'b1;
            tick();
        end
        shift_enable = 1'b0;
        eop = 1'b1;
        tick();
        eop = 1'b0;
        @(negedge clk);
        check("eop_err", rx_error, e_err);
        check("eop_ready", rx_data_ready, e_ready);
        check("eop_active", rx_trans_active, 1'b1);
        tick();
        tick();
        check("flush_cnt", flush_seen, e_flush);
        check("stores_left", exp_q.size(), 0);
        quiet = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        check("rst_outputs", {rx_packet_data, store_rx_packet_data, flush, rx_packet,
                              rx_data_ready, rx_trans_active, rx_error}, 0);
        rst = 1'b0;
        quiet = 1'b1;
        tick();
        tick();

        // DATA1 with 4 payload bytes: last two are CRC and never stored
        pkt = '{8'h80, 8'h4B, 8'h55, 8'hAA, 8'h01, 8'h02};
        run_pkt(0, 0);
        check("p1_pid", rx_packet, 4'hB);
        check("p1_nstores", log_q.size(), 2);
        check("p1_store0", log_q[0], 8'h55);
        check("p1_store1", log_q[1], 8'hAA);

        pkt = '{8'h80, 8'hE1, 8'h12, 8'h34};
        run_pkt(0, 0);
        check("tok_pid", rx_packet, 4'h1);
        check("tok_err", rx_error, 1'b0);
        check("tok_ready", rx_data_ready, 1'b0);

        pkt = '{8'h80, 8'hE1, 8'h12, 8'h34, 8'h56};
        run_pkt(0, 0);
        check("tok3_err", rx_error, 1'b1);

        pkt = '{8'h00, 8'h4B, 8'h11};
        run_pkt(0, 0);
        check("badsync_err", rx_error, 1'b1);
        check("badsync_pid", rx_packet, 4'h1);

        pkt = '{8'h80, 8'hFF};
        run_pkt(0, 0);
        check("badpid_err", rx_error, 1'b1);

        pkt = '{8'h80, 8'hD2};
        run_pkt(0, 0);
        check("ack_pid", rx_packet, 4'h2);
        check("ack_err", rx_error, 1'b0);

        pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(3, 0);
        check("frame_err", rx_error, 1'b1);

        pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(0, 64);
        check("ovf_err", rx_error, 1'b1);
        check("ovf_nstores", log_q.size(), 0);

        pkt = '{8'h80, 8'hC3};
        for (int i = 0; i < MAXP + 2; i++) pkt.push_back(8'(i + 1));
        run_pkt(0, 0);
        check("max_ready", rx_data_ready, 1'b1);
        check("max_nstores", log_q.size(), 64);

        pkt.push_back(8'hEE);
        run_pkt(0, 0);
        check("big_err", rx_error, 1'b1);

        // Reset in the middle of a DATA payload byte
        quiet = 1'b0;
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        send_byte(8'h80);
        send_byte(8'h4B);
        send_byte(8'h11);
        send_byte(8'h22);
        shift_enable = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_active", rx_trans_active, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {rx_packet_data, store_rx_packet_data, flush, rx_packet,
                                  rx_data_ready, rx_trans_active, rx_error}, 0);
        shift_enable = 1'b0;
        tick();
        rst = 1'b0;
        e_err = 1'b0;
        e_ready = 1'b0;
        e_pid = 4'h0;
        exp_q.delete();
        quiet = 1'b1;
        tick();
        tick();

        pkt = '{8'h80, 8'hC3, 8'h12, 8'hAB, 8'hCD};
        run_pkt(0, 0);
        check("post_rst_pid", rx_packet, 4'h3);
        check("post_rst_ready", rx_data_ready, 1'b1);
        check("post_rst_store", log_q[0], 8'h12);

        quiet = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
- Packet-level control FSM for the USB receive path.
- Sits between the bit-level front end (NRZI decoder, bit unstuffer, shift register, EOP detector) and the RX FIFO / protocol interface.
- Validates SYNC and PID, and counts payload bytes by packet type.
- Delays DATA payload by two bytes so the CRC16 is never stored; drives the store, flush, status and error outputs seen by the AHB side.

Parameters:
- MAX_PAYLOAD, 64, maximum DATA payload bytes accepted (CRC excluded); also the FIFO depth.
- OCC_W, 7, width of buffer_occupancy.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- d_edge  in  1  1-cycle pulse on first line transition out of idle (packet start)
- shift_enable  in  1  1-cycle pulse per unstuffed bit
- byte_received  in  1  1-cycle pulse when 8 bits are assembled; coincides with the 8th shift_enable
- rcv_data  in  8  assembled byte, LSB-first order; valid while byte_received=1
- eop  in  1  1-cycle pulse on detected SE0-SE0-J end of packet
- buffer_occupancy  in  OCC_W  current RX FIFO fill
- rx_packet_data  out  8  byte to the FIFO; valid with store_rx_packet_data
- store_rx_packet_data  out  1  1-cycle FIFO write strobe
- flush  out  1  1-cycle FIFO clear pulse
- rx_packet  out  4  last accepted PID
- rx_data_ready  out  1  a good DATA packet is in the FIFO
- rx_trans_active  out  1  a packet is being received
- rx_error  out  1  the last packet was bad

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rx_packet=4'h0; bit_cnt=0; byte_cnt=0; hold registers cleared.
- Reset applied mid-packet aborts the packet immediately, with no store or flush.
- Byte encodings:
  - SYNC byte: rcv_data=8'h80.
  - PID byte: rcv_data[3:0]=PID, rcv_data[7:4]=~PID.
- Legal PIDs:
  - tokens OUT 4'b0001, IN 4'b1001
  - data DATA0 4'b0011, DATA1 4'b1011
  - handshakes ACK 4'b0010, NAK 4'b1010, STALL 4'b1110
  - any other PID, or a check-nibble mismatch, is an error.
- bit_cnt (3-bit) increments on shift_enable, wraps 7->0, and clears on d_edge.
- Any eop arriving while bit_cnt!=0 is a framing error.
- States:
  - IDLE: on d_edge -> SYNC. Same cycle: rx_trans_active<=1, rx_error<=0, rx_data_ready<=0.
  - SYNC: byte_received with 8'h80 -> PID; other byte -> ERR_WAIT; eop -> ERR_DONE.
  - PID: byte_received with legal PID -> latch rx_packet, then:
    - token -> TOKEN (byte_cnt=0)
    - data -> DATA (flush pulses 1 cycle, byte_cnt=0)
    - handshake -> HS_EOP
    - illegal PID -> ERR_WAIT; eop -> ERR_DONE.
  - TOKEN: exactly 2 bytes (addr/endp/CRC5), not stored.
    - 3rd byte -> ERR_WAIT.
    - eop with byte_cnt==2 -> DONE; eop with any other byte_cnt -> ERR_DONE.
  - DATA: 2-deep hold pipeline h0/h1.
    - On each byte with byte_cnt>=2: output h1 on rx_packet_data, pulse store_rx_packet_data the next cycle, then shift h1<=h0, h0<=rcv_data.
    - byte_cnt saturates at MAX_PAYLOAD+2.
    - eop with byte_cnt>=2 -> DONE with rx_data_ready<=1; held bytes (CRC16) discarded.
    - eop with byte_cnt<2 -> ERR_DONE.
    - Overflow: a store when buffer_occupancy==MAX_PAYLOAD, or byte_cnt reaching MAX_PAYLOAD+3, -> ERR_WAIT with no store.
  - HS_EOP: eop -> DONE; byte_received -> ERR_WAIT.
  - ERR_WAIT: ignore bytes; eop -> ERR_DONE.
  - ERR_DONE: rx_error<=1; for a DATA packet flush pulses; -> IDLE.
  - DONE: -> IDLE.
- rx_trans_active falls on the cycle IDLE is entered.
- rx_error and rx_data_ready hold until the next d_edge.
- Simultaneous events:
  - eop and byte_received in the same cycle: the byte is processed first, then the eop.
  - d_edge outside IDLE is ignored.
- Latencies:
  - store is registered: 1 cycle after byte_received.
  - rx_data_ready and rx_error: 1 cycle after eop.

Decomposition:
- Package usb_pkg holds:
  - PID localparams
  - SYNC_BYTE=8'h80
  - the FSM state enum
  - a function pid_valid(byte) returning a validity bit and a pid-class enum (TOKEN/DATA/HS/BAD).
- Sub-module usb_rx_hold2 is natural: the 2-byte CRC-stripping delay line with store strobe.

Test Plan:
- SYNC 8'h80, PID byte 8'h4B (DATA1), bytes 8'h55, 8'hAA, 8'h01, 8'h02, eop at bit_cnt=0:
  - stores 8'h55 then 8'hAA (2 strobes); flush once after PID
  - rx_packet=4'hB, rx_data_ready=1, rx_error=0.
- SYNC, PID 8'hE1 (OUT), 2 bytes, eop -> rx_packet=4'h1, no stores, rx_error=0, rx_data_ready=0. A 3rd byte instead -> rx_error=1 after eop.
- First byte 8'h00 instead of SYNC, then eop -> rx_error=1, rx_packet unchanged, no store.
- PID byte 8'hFF (check mismatch) -> rx_error=1 after eop; a following good ACK packet (PID byte 8'hD2) clears rx_error on its d_edge and ends with rx_packet=4'h2.
- DATA0 packet with eop after 3 extra shift_enables (bit_cnt=3) -> rx_error=1 and flush pulse. DATA0 with buffer_occupancy=64 at first store -> overflow error, zero strobes.
- rst asserted mid-DATA payload -> outputs 0 asynchronously; the next full DATA0 packet with payload 8'h12 is received correctly.
